// File: rtl/mul_issue_scheduler_pkg.sv
// Shared types for the MUL reservation station: entry layout, FSM states, counter widths.
// Entry field widths are fixed here; the scheduler's XLEN/TAG_W parameters must match them.
package mul_sched_pkg;

  localparam int unsigned RS_XLEN  = 32;
  localparam int unsigned RS_TAG_W = 5;
  localparam int unsigned AGE_W    = 6;
  localparam int unsigned WDOG_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } sched_state_e;

  typedef struct packed {
    logic                valid;
    logic [RS_TAG_W-1:0] rd;
    logic                a_rdy;
    logic [RS_TAG_W-1:0] a_tag;
    logic [RS_XLEN-1:0]  a;
    logic                b_rdy;
    logic [RS_TAG_W-1:0] b_tag;
    logic [RS_XLEN-1:0]  b;
    logic [AGE_W-1:0]    age;
  } rs_entry_t;

  // x is older than y when x-y is negative modulo 2^AGE_W
  function automatic logic age_older(input logic [AGE_W-1:0] x, input logic [AGE_W-1:0] y);
    logic [AGE_W-1:0] d;
    d = x - y;
    return d[AGE_W-1];
  endfunction

endpackage

// File: rtl/mul_issue_scheduler_picker.sv
// Combinational oldest-ready selection: one-hot grant to the ready entry with the oldest age.
module oldest_ready_picker
  import mul_sched_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4
) (
  input  logic [NUM_ENTRIES-1:0]            ready,
  input  logic [NUM_ENTRIES-1:0][AGE_W-1:0] ages,
  output logic [NUM_ENTRIES-1:0]            grant,
  output logic                              any_ready
);

  // Equal ages cannot occur among live entries; the index tie-break keeps grant one-hot regardless.
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      grant[i] = ready[i];
      for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && ready[j] &&
            (age_older(ages[j], ages[i]) || (ages[j] == ages[i] && j < i)))
          grant[i] = 1'b0;
      end
    end
  end

  assign any_ready = |ready;

endmodule

// File: rtl/mul_issue_scheduler.sv
// Reservation station and issue controller for the non-pipelined multiplier:
// captures operands from the CDB, issues the oldest ready op, and holds its result for writeback.
module mul_issue_scheduler
  import mul_sched_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned XLEN        = RS_XLEN,
  parameter int unsigned TAG_W       = RS_TAG_W,
  parameter int unsigned MUL_LATENCY = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [TAG_W-1:0]             disp_rd,
  input  logic                         disp_a_rdy,
  input  logic [TAG_W-1:0]             disp_a_tag,
  input  logic [XLEN-1:0]              disp_a,
  input  logic                         disp_b_rdy,
  input  logic [TAG_W-1:0]             disp_b_tag,
  input  logic [XLEN-1:0]              disp_b,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  output logic                         mul_start,
  output logic [TAG_W-1:0]             mul_rd,
  output logic [XLEN-1:0]              mul_a,
  output logic [XLEN-1:0]              mul_b,
  input  logic                         mul_done,
  input  logic [XLEN-1:0]              mul_result,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [TAG_W-1:0]             wb_rd,
  output logic [XLEN-1:0]              wb_data,
  output logic [$clog2(NUM_ENTRIES):0] occupancy,
  output logic                         timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  rs_entry_t                         entries     [NUM_ENTRIES];
  rs_entry_t                         entries_nxt [NUM_ENTRIES];
  rs_entry_t                         new_entry;
  rs_entry_t                         sel_entry;
  sched_state_e                      state, state_nxt;
  logic [NUM_ENTRIES-1:0]            ready_vec;
  logic [NUM_ENTRIES-1:0]            free_oh;
  logic [NUM_ENTRIES-1:0]            grant;
  logic [NUM_ENTRIES-1:0][AGE_W-1:0] ages;
  logic                              any_ready;
  logic                              found_free;
  logic                              dispatch_fire;
  logic                              issue_fire;
  logic                              done_fire;
  logic                              wb_fire;
  logic                              wdog_expire;
  logic [AGE_W-1:0]                  age_ctr;
  logic [WDOG_W-1:0]                 wdog;

  always_comb begin
    free_oh    = '0;
    found_free = 1'b0;
    occupancy  = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      ready_vec[i] = entries[i].valid && entries[i].a_rdy && entries[i].b_rdy;
      ages[i]      = entries[i].age;
      occupancy    = occupancy + {{IDX_W{1'b0}}, entries[i].valid};
      if (!entries[i].valid && !found_free) begin
        free_oh[i] = 1'b1;
        found_free = 1'b1;
      end
    end
  end

  assign disp_ready    = found_free;
  assign dispatch_fire = disp_valid && disp_ready && !flush;

  oldest_ready_picker #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_picker (
    .ready    (ready_vec),
    .ages     (ages),
    .grant    (grant),
    .any_ready(any_ready)
  );

  // A dispatching operand whose producer is on the CDB this cycle is captured on write.
  always_comb begin
    new_entry       = '0;
    new_entry.valid = 1'b1;
    new_entry.rd    = disp_rd;
    new_entry.a_tag = disp_a_tag;
    new_entry.b_tag = disp_b_tag;
    new_entry.age   = age_ctr;
    new_entry.a_rdy = disp_a_rdy;
    new_entry.a     = disp_a;
    new_entry.b_rdy = disp_b_rdy;
    new_entry.b     = disp_b;
    if (!disp_a_rdy && cdb_valid && cdb_tag == disp_a_tag) begin
      new_entry.a_rdy = 1'b1;
      new_entry.a     = cdb_data;
    end
    if (!disp_b_rdy && cdb_valid && cdb_tag == disp_b_tag) begin
      new_entry.b_rdy = 1'b1;
      new_entry.b     = cdb_data;
    end
  end

  always_comb begin
    sel_entry = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (grant[i])
        sel_entry = entries[i];
    end
  end

  // The issued entry is never the free one, so issue-clear and dispatch-write are disjoint.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      entries_nxt[i] = entries[i];
      if (entries[i].valid && !entries[i].a_rdy && cdb_valid && cdb_tag == entries[i].a_tag) begin
        entries_nxt[i].a_rdy = 1'b1;
        entries_nxt[i].a     = cdb_data;
      end
      if (entries[i].valid && !entries[i].b_rdy && cdb_valid && cdb_tag == entries[i].b_tag) begin
        entries_nxt[i].b_rdy = 1'b1;
        entries_nxt[i].b     = cdb_data;
      end
      if (issue_fire && grant[i])
        entries_nxt[i].valid = 1'b0;
      if (dispatch_fire && free_oh[i])
        entries_nxt[i] = new_entry;
      if (flush)
        entries_nxt[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++)
        entries[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++)
        entries[i] <= entries_nxt[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mul_start   = 1'b0;
    issue_fire  = 1'b0;
    done_fire   = 1'b0;
    wb_fire     = 1'b0;
    wdog_expire = 1'b0;
    case (state)
      IDLE: begin
        if (any_ready) begin
          issue_fire = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          done_fire = 1'b1;
          state_nxt = WB;
        end else if (wdog == '0) begin
          wdog_expire = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WB: begin
        if (wb_ready) begin
          wb_fire   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt   = IDLE;
      issue_fire  = 1'b0;
      done_fire   = 1'b0;
      wb_fire     = 1'b0;
      wdog_expire = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_ctr     <= '0;
      wdog        <= '0;
      mul_rd      <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (dispatch_fire)
        age_ctr <= age_ctr + AGE_W'(1);
      if (issue_fire) begin
        mul_rd <= sel_entry.rd;
        mul_a  <= sel_entry.a;
        mul_b  <= sel_entry.b;
      end
      if (state == ISSUE)
        wdog <= WDOG_W'(MUL_LATENCY + 2);
      else if (state == WAIT && wdog != '0)
        wdog <= wdog - WDOG_W'(1);
      if (done_fire) begin
        wb_valid <= 1'b1;
        wb_rd    <= mul_rd;
        wb_data  <= mul_result;
      end
      if (wb_fire || flush)
        wb_valid <= 1'b0;
      if (wdog_expire)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_issue_scheduler.sv
// Directed bench for mul_issue_scheduler: one task per scenario, inline expected-value checks.
module tb_mul_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [4:0]  disp_rd = '0;
  logic        disp_a_rdy = 1'b0;
  logic [4:0]  disp_a_tag = '0;
  logic [31:0] disp_a = '0;
  logic        disp_b_rdy = 1'b0;
  logic [4:0]  disp_b_tag = '0;
  logic [31:0] disp_b = '0;
  logic        cdb_valid = 1'b0;
  logic [4:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        mul_start;
  logic [4:0]  mul_rd;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done = 1'b0;
  logic [31:0] mul_result = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  occupancy;
  logic        timeout_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mul_issue_scheduler #(
    .NUM_ENTRIES(4),
    .XLEN(32),
    .TAG_W(5),
    .MUL_LATENCY(6)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
    .disp_a_rdy(disp_a_rdy), .disp_a_tag(disp_a_tag), .disp_a(disp_a),
    .disp_b_rdy(disp_b_rdy), .disp_b_tag(disp_b_tag), .disp_b(disp_b),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .mul_start(mul_start), .mul_rd(mul_rd), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .occupancy(occupancy), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input logic [4:0] rd, input logic ar, input logic [4:0] at,
                            input logic [31:0] a, input logic br, input logic [4:0] bt,
                            input logic [31:0] b);
    disp_valid = 1'b1; disp_rd = rd;
    disp_a_rdy = ar; disp_a_tag = at; disp_a = a;
    disp_b_rdy = br; disp_b_tag = bt; disp_b = b;
  endtask

  // Called in the ISSUE cycle; returns in IDLE after the result is written back.
  task automatic complete_op(input logic [31:0] r);
    tick();
    mul_done = 1'b1; mul_result = r;
    tick();
    mul_done = 1'b0; wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests_run++;
    if ({mul_start, wb_valid, timeout_err, occupancy} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got start=%0b wbv=%0b to=%0b occ=%0d want all 0",
               mul_start, wb_valid, timeout_err, occupancy);
    end
    tests_run++;
    if ({mul_rd, mul_a, mul_b, wb_rd, wb_data} !== 106'b0) begin
      tests_failed++;
      $display("FAIL reset_data: got rd=%0d a=%0d b=%0d wbrd=%0d wbdata=%0d want all 0",
               mul_rd, mul_a, mul_b, wb_rd, wb_data);
    end
    tests_run++;
    if (disp_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_disp_ready: got %0b want 1", disp_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_issue();
    drive_disp(5'd3, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd6);
    tick();
    disp_valid = 1'b0;
    tests_run++;
    if (mul_start !== 1'b0) begin
      tests_failed++; $display("FAIL basic_no_early_start: got %0b want 0", mul_start);
    end
    tick();
    tests_run++;
    if ({mul_start, mul_rd, mul_a, mul_b} !== {1'b1, 5'd3, 32'd7, 32'd6}) begin
      tests_failed++;
      $display("FAIL basic_issue: got start=%0b rd=%0d a=%0d b=%0d want 1/3/7/6",
               mul_start, mul_rd, mul_a, mul_b);
    end
    tick();
    tests_run++;
    if (mul_start !== 1'b0) begin
      tests_failed++; $display("FAIL basic_start_one_cycle: got %0b want 0", mul_start);
    end
    mul_done = 1'b1; mul_result = 32'd42;
    tick();
    mul_done = 1'b0;
    tests_run++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd3, 32'd42}) begin
      tests_failed++;
      $display("FAIL basic_wb: got v=%0b rd=%0d data=%0d want 1/3/42", wb_valid, wb_rd, wb_data);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    tests_run++;
    if (wb_valid !== 1'b0 || occupancy !== 3'd0) begin
      tests_failed++;
      $display("FAIL basic_wb_done: got v=%0b occ=%0d want 0/0", wb_valid, occupancy);
    end
  endtask

  task automatic test_cdb_capture();
    drive_disp(5'd4, 1'b0, 5'd9, 32'd0, 1'b1, 5'd0, 32'd3);
    tick();
    disp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mul_start !== 1'b0) begin
        tests_failed++; $display("FAIL cdb_no_issue_pending: got %0b want 0 (cycle %0d)", mul_start, i);
      end
      tick();
    end
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'd5;
    tick();
    cdb_valid = 1'b0;
    tests_run++;
    if (mul_start !== 1'b0) begin
      tests_failed++; $display("FAIL cdb_capture_cycle: got start %0b want 0", mul_start);
    end
    tick();
    tests_run++;
    if ({mul_start, mul_rd, mul_a, mul_b} !== {1'b1, 5'd4, 32'd5, 32'd3}) begin
      tests_failed++;
      $display("FAIL cdb_issue: got start=%0b rd=%0d a=%0d b=%0d want 1/4/5/3",
               mul_start, mul_rd, mul_a, mul_b);
    end
    tick();
    mul_done = 1'b1; mul_result = 32'd15;
    tick();
    mul_done = 1'b0;
    tests_run++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd4, 32'd15}) begin
      tests_failed++;
      $display("FAIL cdb_wb: got v=%0b rd=%0d data=%0d want 1/4/15", wb_valid, wb_rd, wb_data);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_cdb_bypass();
    drive_disp(5'd21, 1'b0, 5'd12, 32'd0, 1'b1, 5'd0, 32'd4);
    cdb_valid = 1'b1; cdb_tag = 5'd12; cdb_data = 32'd11;
    tick();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    tests_run++;
    if ({mul_start, mul_rd, mul_a} !== {1'b1, 5'd21, 32'd11}) begin
      tests_failed++;
      $display("FAIL bypass_issue: got start=%0b rd=%0d a=%0d want 1/21/11", mul_start, mul_rd, mul_a);
    end
    complete_op(32'd44);
  endtask

  task automatic test_full();
    logic [4:0] exp_rd [4];
    exp_rd[0] = 5'd11; exp_rd[1] = 5'd12; exp_rd[2] = 5'd13; exp_rd[3] = 5'd15;
    for (int k = 0; k < 4; k++) begin
      drive_disp(5'(10 + k), 1'b0, 5'd20, 32'd0, 1'b1, 5'd0, 32'(k + 1));
      tick();
    end
    drive_disp(5'd14, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 32'd9);
    tests_run++;
    if (disp_ready !== 1'b0 || occupancy !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_state: got ready=%0b occ=%0d want 0/4", disp_ready, occupancy);
    end
    tick();
    disp_valid = 1'b0;
    tests_run++;
    if (occupancy !== 3'd4 || mul_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_reject: got occ=%0d start=%0b want 4/0", occupancy, mul_start);
    end
    cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_data = 32'd2;
    tick();
    cdb_valid = 1'b0;
    tick();
    tests_run++;
    if ({mul_start, mul_rd, mul_a, disp_ready, occupancy} !== {1'b1, 5'd10, 32'd2, 1'b1, 3'd3}) begin
      tests_failed++;
      $display("FAIL full_first_issue: got start=%0b rd=%0d a=%0d ready=%0b occ=%0d want 1/10/2/1/3",
               mul_start, mul_rd, mul_a, disp_ready, occupancy);
    end
    // Youngest op lands in the freed lowest index; it must still issue last.
    drive_disp(5'd15, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1);
    tick();
    disp_valid = 1'b0;
    tests_run++;
    if (occupancy !== 3'd4) begin
      tests_failed++; $display("FAIL full_refill: got occ=%0d want 4", occupancy);
    end
    mul_done = 1'b1; mul_result = 32'd2;
    tick();
    mul_done = 1'b0; wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (mul_start !== 1'b1 || mul_rd !== exp_rd[k]) begin
        tests_failed++;
        $display("FAIL full_order_%0d: got start=%0b rd=%0d want 1/%0d", k, mul_start, mul_rd, exp_rd[k]);
      end
      complete_op(32'(100 + k));
    end
    tests_run++;
    if (occupancy !== 3'd0) begin
      tests_failed++; $display("FAIL full_drained: got occ=%0d want 0", occupancy);
    end
  endtask

  task automatic test_back_to_back();
    drive_disp(5'd1, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 32'd3);
    tick();
    drive_disp(5'd2, 1'b1, 5'd0, 32'd4, 1'b1, 5'd0, 32'd5);
    tick();
    disp_valid = 1'b0;
    tests_run++;
    if ({mul_start, mul_rd, occupancy} !== {1'b1, 5'd1, 3'd1}) begin
      tests_failed++;
      $display("FAIL b2b_first: got start=%0b rd=%0d occ=%0d want 1/1/1", mul_start, mul_rd, occupancy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (mul_start !== 1'b0) begin
        tests_failed++; $display("FAIL b2b_wait_nostart: got %0b want 0 (cycle %0d)", mul_start, i);
      end
    end
    mul_done = 1'b1; mul_result = 32'd6;
    tick();
    mul_done = 1'b0;
    tests_run++;
    if ({wb_valid, wb_rd, mul_start} !== {1'b1, 5'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_wb: got v=%0b rd=%0d start=%0b want 1/1/0", wb_valid, wb_rd, mul_start);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    tests_run++;
    if (mul_start !== 1'b0 || wb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: got start=%0b v=%0b want 0/0", mul_start, wb_valid);
    end
    tick();
    tests_run++;
    if ({mul_start, mul_rd, mul_a, mul_b} !== {1'b1, 5'd2, 32'd4, 32'd5}) begin
      tests_failed++;
      $display("FAIL b2b_second: got start=%0b rd=%0d a=%0d b=%0d want 1/2/4/5",
               mul_start, mul_rd, mul_a, mul_b);
    end
    complete_op(32'd20);
  endtask

  task automatic test_wb_stall();
    drive_disp(5'd5, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 32'd11);
    tick();
    drive_disp(5'd6, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1);
    tick();
    disp_valid = 1'b0;
    tick();
    mul_done = 1'b1; mul_result = 32'd99;
    tick();
    mul_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({wb_valid, wb_rd, wb_data, mul_start} !== {1'b1, 5'd5, 32'd99, 1'b0}) begin
        tests_failed++;
        $display("FAIL stall_hold: got v=%0b rd=%0d data=%0d start=%0b want 1/5/99/0 (cycle %0d)",
                 wb_valid, wb_rd, wb_data, mul_start, i);
      end
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    tests_run++;
    if (wb_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stall_release: got v=%0b want 0", wb_valid);
    end
    tick();
    tests_run++;
    if (mul_start !== 1'b1 || mul_rd !== 5'd6) begin
      tests_failed++;
      $display("FAIL stall_next_issue: got start=%0b rd=%0d want 1/6", mul_start, mul_rd);
    end
    complete_op(32'd1);
  endtask

  task automatic test_timeout_flush();
    int n;
    drive_disp(5'd7, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd3);
    tick();
    disp_valid = 1'b0;
    tick();
    tick();
    n = 0;
    while (timeout_err !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != 9) begin
      tests_failed++; $display("FAIL timeout_cycles: got %0d cycles in WAIT want 9", n);
    end
    drive_disp(5'd8, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 32'd2);
    tick();
    disp_valid = 1'b0;
    tick();
    tests_run++;
    if (mul_start !== 1'b1 || mul_rd !== 5'd8) begin
      tests_failed++;
      $display("FAIL timeout_idle_reissue: got start=%0b rd=%0d want 1/8", mul_start, mul_rd);
    end
    tick();
    drive_disp(5'd9, 1'b0, 5'd30, 32'd0, 1'b1, 5'd0, 32'd1);
    tick();
    disp_valid = 1'b0;
    tests_run++;
    if (occupancy !== 3'd1) begin
      tests_failed++; $display("FAIL flush_pre_occ: got %0d want 1", occupancy);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if ({occupancy, wb_valid, timeout_err} !== {3'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL flush_state: got occ=%0d v=%0b to=%0b want 0/0/1", occupancy, wb_valid, timeout_err);
    end
    mul_done = 1'b1; mul_result = 32'd55;
    tick();
    mul_done = 1'b0;
    tick();
    tests_run++;
    if (wb_valid !== 1'b0 || mul_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_late_done: got v=%0b start=%0b want 0/0", wb_valid, mul_start);
    end
  endtask

  task automatic test_reset_mid_op();
    drive_disp(5'd25, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd11);
    tick();
    disp_valid = 1'b0;
    tick();
    tick();
    mul_done = 1'b1; mul_result = 32'd77;
    drive_disp(5'd26, 1'b0, 5'd3, 32'd0, 1'b1, 5'd0, 32'd1);
    tick();
    mul_done = 1'b0; disp_valid = 1'b0;
    tests_run++;
    if ({wb_valid, wb_data, occupancy, timeout_err} !== {1'b1, 32'd77, 3'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL midrst_pre: got v=%0b data=%0d occ=%0d to=%0b want 1/77/1/1",
               wb_valid, wb_data, occupancy, timeout_err);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({wb_valid, wb_data, occupancy, timeout_err, mul_a} !== 69'b0) begin
      tests_failed++;
      $display("FAIL midrst_async: got v=%0b data=%0d occ=%0d to=%0b a=%0d want all 0",
               wb_valid, wb_data, occupancy, timeout_err, mul_a);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_cdb_capture();
    test_cdb_bypass();
    test_full();
    test_back_to_back();
    test_wb_stall();
    test_timeout_flush();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "time limit");
  end

endmodule
